// File: rtl/mmio_fabric.sv
// Single-master memory-mapped access fabric: decodes a core load/store onto one
// of NUM_SLAVES slave ports, waits for the slave ack (bounded), and returns a one-cycle response.
module mmio_fabric #(
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_BASE =
        {32'h0003_2000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*32-1:0] SLAVE_MASK =
        {32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_C000},
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [1:0]               req_size,
    input  logic                     req_unsigned,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    output logic [31:0]              resp_rdata,
    output logic                     resp_err,
    output logic [NUM_SLAVES-1:0]    s_sel,
    output logic                     s_we,
    output logic [3:0]               s_be,
    output logic [31:0]              s_addr,
    output logic [31:0]              s_wdata,
    input  logic [NUM_SLAVES*32-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]    s_ack
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [1:0]            state_reg;
    logic [NUM_SLAVES-1:0] sel_reg;
    logic                  we_reg;
    logic [3:0]            be_reg;
    logic [31:0]           addr_reg;
    logic [31:0]           wdata_reg;
    logic [1:0]            size_reg;
    logic                  uns_reg;
    logic [31:0]           rdata_reg;
    logic [15:0]           cnt_reg;

    // ---------------- request decode ----------------
    logic [NUM_SLAVES-1:0] hit;
    logic [NUM_SLAVES-1:0] sel_next;
    logic                  found;
    logic                  misalign;
    logic                  bad_req;
    logic [3:0]            be_next;
    logic [31:0]           wdata_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
            assign hit[gi] = (req_addr & SLAVE_MASK[32*gi +: 32]) == SLAVE_BASE[32*gi +: 32];
        end
    endgenerate

    // Overlapping windows resolve to the lowest slave index.
    always_comb begin
        sel_next = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (hit[i] && !found) begin
                sel_next[i] = 1'b1;
                found       = 1'b1;
            end
        end
    end

    always_comb begin
        misalign   = 1'b0;
        be_next    = 4'b1111;
        wdata_next = req_wdata;
        case (req_size)
            2'b00: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misalign   = req_addr[0];
                be_next    = 4'b0011 << req_addr[1:0];
                wdata_next = {2{req_wdata[15:0]}};
            end
            default: misalign = (req_addr[1:0] != 2'b00);
        endcase
    end

    assign bad_req = (req_size == 2'b11) || misalign || !found;

    // ---------------- read path ----------------
    logic [31:0] sel_rdata;
    logic        ack_hit;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    always_comb begin
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            sel_rdata = sel_rdata | (s_rdata[32*i +: 32] & {32{sel_reg[i]}});
        end
    end

    assign ack_hit = |(s_ack & sel_reg);

    always_comb begin
        byte_lane = sel_rdata[7:0];
        case (addr_reg[1:0])
            2'd1:    byte_lane = sel_rdata[15:8];
            2'd2:    byte_lane = sel_rdata[23:16];
            2'd3:    byte_lane = sel_rdata[31:24];
            default: byte_lane = sel_rdata[7:0];
        endcase
        half_lane = addr_reg[1] ? sel_rdata[31:16] : sel_rdata[15:0];
        case (size_reg)
            2'b00:   load_data = {{24{byte_lane[7] & ~uns_reg}}, byte_lane};
            2'b01:   load_data = {{16{half_lane[15] & ~uns_reg}}, half_lane};
            default: load_data = sel_rdata;
        endcase
    end

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            we_reg    <= 1'b0;
            be_reg    <= 4'b0000;
            addr_reg  <= '0;
            wdata_reg <= '0;
            size_reg  <= 2'b00;
            uns_reg   <= 1'b0;
            rdata_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (bad_req) begin
                            state_reg <= ST_ERR;
                        end else begin
                            state_reg <= ST_WAIT;
                            sel_reg   <= sel_next;
                            we_reg    <= req_we;
                            be_reg    <= be_next;
                            addr_reg  <= req_addr;
                            wdata_reg <= wdata_next;
                            size_reg  <= req_size;
                            uns_reg   <= req_unsigned;
                            cnt_reg   <= '0;
                        end
                    end
                end
                ST_WAIT: begin
                    // An ack in the last allowed cycle still wins over the timeout.
                    if (ack_hit) begin
                        state_reg <= ST_RESP;
                        sel_reg   <= '0;
                        rdata_reg <= we_reg ? 32'h0 : load_data;
                    end else if (cnt_reg == CNT_LAST) begin
                        state_reg <= ST_ERR;
                        sel_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_reg == ST_IDLE);
    assign resp_valid = (state_reg == ST_RESP) || (state_reg == ST_ERR);
    assign resp_err   = (state_reg == ST_ERR);
    assign resp_rdata = (state_reg == ST_RESP) ? rdata_reg : 32'h0;
    assign s_sel      = sel_reg;
    assign s_we       = we_reg;
    assign s_be       = be_reg;
    assign s_addr     = addr_reg;
    assign s_wdata    = wdata_reg;

endmodule

// File: tb/tb_mmio_fabric.sv
// Directed bench for mmio_fabric: hand-computed vectors for decode, lane handling,
// error paths, timeout, ignored foreign acks and reset during an access.
module tb_mmio_fabric;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic [1:0]   req_size;
    logic         req_unsigned;
    logic [31:0]  req_addr;
    logic [31:0]  req_wdata;
    logic         resp_valid;
    logic [31:0]  resp_rdata;
    logic         resp_err;
    logic [3:0]   s_sel;
    logic         s_we;
    logic [3:0]   s_be;
    logic [31:0]  s_addr;
    logic [31:0]  s_wdata;
    logic [127:0] s_rdata;
    logic [3:0]   s_ack;

    int err_cnt = 0;
    int chk_cnt = 0;

    mmio_fabric #(.TIMEOUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .s_sel        (s_sel),
        .s_we         (s_we),
        .s_be         (s_be),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_rdata      (s_rdata),
        .s_ack        (s_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for one cycle; on return the bench sits in cycle 1.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        chk("ready_at_hs", {31'h0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
        req_we    = 1'b0;
    endtask

    task automatic expect_err(input string tag, input logic [1:0] size, input logic [31:0] addr);
        issue(1'b0, size, 1'b0, addr, 32'h0);
        chk({tag, "_valid"}, {31'h0, resp_valid}, 32'h1);
        chk({tag, "_err"},   {31'h0, resp_err},   32'h1);
        chk({tag, "_rdata"}, resp_rdata, 32'h0);
        chk({tag, "_sel"},   {28'h0, s_sel}, 32'h0);
        tick();
        chk({tag, "_done"},  {30'h0, resp_valid, req_ready}, 32'h1);
        $display("txn %s addr=%h size=%0d -> error response", tag, addr, size);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        s_rdata = '0; s_ack = '0;
        tick();
        tick();
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp",  {30'h0, resp_valid, resp_err}, 32'h0);
        chk("rst_sel",   {28'h0, s_sel}, 32'h0);
        chk("rst_we_be", {27'h0, s_we, s_be}, 32'h0);
        chk("rst_rdata", resp_rdata, 32'h0);
        rst_n = 1'b1;
        tick();

        // LB sign-extended from lane 3, same-cycle ack
        s_rdata[31:0] = 32'h80AA_BBCC;
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0);
        chk("lb_sel", {28'h0, s_sel}, 32'h1);
        chk("lb_be",  {28'h0, s_be},  32'h8);
        chk("lb_we",  {31'h0, s_we},  32'h0);
        s_ack = 4'b0001;
        tick();
        s_ack = 4'b0000;
        chk("lb_valid", {30'h0, resp_valid, resp_err}, 32'h2);
        chk("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        chk("lb_sel_off", {28'h0, s_sel}, 32'h0);
        tick();
        chk("lb_done", {30'h0, resp_valid, req_ready}, 32'h1);
        $display("txn LB addr=00000003 rdata=%h", 32'hFFFF_FF80);

        // SH to slave1, lane replication
        s_rdata[63:32] = 32'hDEAD_BEEF;
        issue(1'b1, 2'b01, 1'b0, 32'h0001_0002, 32'h0000_1234);
        chk("sh_sel",   {28'h0, s_sel}, 32'h2);
        chk("sh_be",    {28'h0, s_be},  32'hC);
        chk("sh_we",    {31'h0, s_we},  32'h1);
        chk("sh_wdata", s_wdata, 32'h1234_1234);
        chk("sh_addr",  s_addr,  32'h0001_0002);
        s_ack = 4'b0010;
        tick();
        s_ack = 4'b0000;
        chk("sh_resp",  {30'h0, resp_valid, resp_err}, 32'h2);
        chk("sh_rdata", resp_rdata, 32'h0);
        tick();
        $display("txn SH addr=00010002 wdata=00001234 -> ok");

        // SB lane replication and byte enable
        issue(1'b1, 2'b00, 1'b0, 32'h0002_0001, 32'h0000_00A5);
        chk("sb_be",    {28'h0, s_be}, 32'h2);
        chk("sb_wdata", s_wdata, 32'hA5A5_A5A5);
        chk("sb_sel",   {28'h0, s_sel}, 32'h4);
        s_ack = 4'b0100;
        tick();
        s_ack = 4'b0000;
        chk("sb_resp", {30'h0, resp_valid, resp_err}, 32'h2);
        tick();
        $display("txn SB addr=00020001 wdata=000000a5 -> ok");

        // LH signed from low half, LW ignoring req_unsigned
        s_rdata[31:0] = 32'h1111_8001;
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0);
        s_ack = 4'b0001;
        tick();
        s_ack = 4'b0000;
        chk("lh_rdata", resp_rdata, 32'hFFFF_8001);
        tick();
        $display("txn LH addr=00000000 rdata=ffff8001");
        s_rdata[95:64] = 32'h89AB_CDEF;
        issue(1'b0, 2'b10, 1'b1, 32'h0002_0004, 32'h0);
        chk("lw_be", {28'h0, s_be}, 32'hF);
        s_ack = 4'b0100;
        tick();
        s_ack = 4'b0000;
        chk("lw_rdata", resp_rdata, 32'h89AB_CDEF);
        tick();
        $display("txn LW addr=00020004 rdata=89abcdef");

        // error paths: misaligned, illegal size, unmapped
        expect_err("lw_misalign", 2'b10, 32'h0000_0006);
        expect_err("lh_misalign", 2'b01, 32'h0001_0001);
        expect_err("size11",      2'b11, 32'h0000_0000);
        expect_err("nohit",       2'b10, 32'h0005_0000);

        // timeout on slave1 after exactly 4 WAIT cycles
        issue(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            chk("to_sel",  {28'h0, s_sel}, 32'h2);
            chk("to_wait", {31'h0, resp_valid}, 32'h0);
            tick();
        end
        chk("to_err",   {30'h0, resp_valid, resp_err}, 32'h3);
        chk("to_rdata", resp_rdata, 32'h0);
        chk("to_sel0",  {28'h0, s_sel}, 32'h0);
        tick();
        $display("txn LW addr=00010000 no ack -> timeout error");

        // LHU on slave3, ack in 4th WAIT cycle, foreign slave0 ack ignored
        s_rdata = {32'hF00D_0000, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678};
        issue(1'b0, 2'b01, 1'b1, 32'h0003_2002, 32'h0);
        for (int c = 1; c <= 3; c++) begin
            s_ack = (c == 2) ? 4'b0001 : 4'b0000;
            chk("lhu_sel",  {28'h0, s_sel}, 32'h8);
            chk("lhu_wait", {31'h0, resp_valid}, 32'h0);
            tick();
        end
        s_ack = 4'b1000;
        chk("lhu_sel4", {28'h0, s_sel}, 32'h8);
        tick();
        s_ack = 4'b0000;
        chk("lhu_resp",  {30'h0, resp_valid, resp_err}, 32'h2);
        chk("lhu_rdata", resp_rdata, 32'h0000_F00D);
        tick();
        $display("txn LHU addr=00032002 rdata=0000f00d");

        // reset during WAIT
        issue(1'b0, 2'b10, 1'b0, 32'h0001_0000, 32'h0);
        chk("rw_sel", {28'h0, s_sel}, 32'h2);
        rst_n = 1'b0;
        #1;
        chk("rw_sel_drop", {28'h0, s_sel}, 32'h0);
        chk("rw_noresp",   {31'h0, resp_valid}, 32'h0);
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rw_after", {30'h0, resp_valid, req_ready}, 32'h1);
        end
        $display("txn reset during WAIT -> aborted");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
